mem_issue_queue: RTL and testbench

//  In-order load/store issue queue feeding the LSU. Dispatch writes memory ops in program order.

---
 rtl/mem_issue_queue_pkg.sv | 18 +
 rtl/mem_issue_queue_operand.sv | 62 ++++++
 rtl/mem_issue_queue.sv | 174 +++++++++++++++++
 tb/tb_mem_issue_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_issue_queue_pkg.sv
// Shared widths and memory-op encodings for the load/store issue queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_issue_queue_pkg;

  localparam int MIQ_MEM_OP_W   = 4;
  localparam int MIQ_ROB_IDX_W  = 5;
  localparam int MIQ_PREG_IDX_W = 6;

  // Access-size encodings carried through to the LSU untouched.
  typedef enum logic [MIQ_MEM_OP_W-1:0] {
    MEM_OP_B  = 4'd0,
    MEM_OP_H  = 4'd1,
    MEM_OP_W  = 4'd2,
    MEM_OP_FW = 4'd3
  } mem_op_e;

endpackage

// File: rtl/mem_issue_queue_operand.sv
// One source operand of a queue entry: tag/ready/value with CDB wakeup and dispatch bypass.
// Latency: a CDB hit becomes visible on rdy/val the cycle after the broadcast.
// Backpressure: none; the slot is written whenever its entry is dispatched.
module miq_operand_slot
  import mem_issue_queue_pkg::*;
#(
  parameter int PREG_W = MIQ_PREG_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              entry_valid,
  input  logic              wr,
  input  logic [PREG_W-1:0] wr_tag,
  input  logic              wr_fp,
  input  logic              wr_rdy,
  input  logic [31:0]       wr_val,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_tag,
  input  logic              cdb_is_fp,
  input  logic [31:0]       cdb_value,
  output logic              rdy,
  output logic [31:0]       val
);

  logic [PREG_W-1:0] tag;
  logic              fp;
  logic              hit_held;
  logic              hit_new;

  // Held tag is compared for wakeup; incoming tag is compared for the dispatch bypass.
  assign hit_held = cdb_valid && (cdb_tag == tag) && (cdb_is_fp == fp);
  assign hit_new  = cdb_valid && (cdb_tag == wr_tag) && (cdb_is_fp == wr_fp);

  // Operand capture: dispatch write (with same-cycle CDB bypass) or later wakeup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag <= '0;
      fp  <= 1'b0;
      rdy <= 1'b0;
      val <= '0;
    end else if (flush) begin
      rdy <= 1'b0;
    end else if (wr) begin
      tag <= wr_tag;
      fp  <= wr_fp;
      if (wr_rdy) begin
        rdy <= 1'b1;
        val <= wr_val;
      end else if (hit_new) begin
        rdy <= 1'b1;
        val <= cdb_value;
      end else begin
        rdy <= 1'b0;
      end
    end else if (entry_valid && !rdy && hit_held) begin
      rdy <= 1'b1;
      val <= cdb_value;
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: captures operands from the CDB, issues head with base+imm.
// Latency: dispatched ready op issues the next cycle; issue is combinational from queue state.
// Backpressure: disp_ready drops when full (no pop bypass); lsu_busy stalls the head.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int MEM_OP_WIDTH   = MIQ_MEM_OP_W,
  parameter int ROB_IDX_WIDTH  = MIQ_ROB_IDX_W,
  parameter int PREG_IDX_WIDTH = MIQ_PREG_IDX_W,
  localparam int PTR_W         = $clog2(DEPTH) + 1,
  localparam int IDX_W         = PTR_W - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [PREG_IDX_WIDTH-1:0] disp_base_tag,
  input  logic                      disp_base_rdy,
  input  logic [31:0]               disp_base_val,
  input  logic [PREG_IDX_WIDTH-1:0] disp_data_tag,
  input  logic                      disp_data_fp,
  input  logic                      disp_data_rdy,
  input  logic [31:0]               disp_data_val,
  input  logic [31:0]               disp_imm,
  input  logic [MEM_OP_WIDTH-1:0]   disp_mem_op,
  input  logic                      disp_is_load,
  input  logic                      disp_unsigned,
  input  logic [ROB_IDX_WIDTH-1:0]  disp_rob_idx,
  input  logic [PREG_IDX_WIDTH-1:0] disp_rd_tag,
  input  logic                      disp_rd_is_fp,
  input  logic                      cdb_valid,
  input  logic [PREG_IDX_WIDTH-1:0] cdb_tag,
  input  logic                      cdb_is_fp,
  input  logic [31:0]               cdb_value,
  input  logic                      lsu_busy,
  output logic                      iss_valid,
  output logic [31:0]               iss_addr,
  output logic [31:0]               iss_wdata,
  output logic [MEM_OP_WIDTH-1:0]   iss_mem_op,
  output logic                      iss_is_load,
  output logic                      iss_unsigned,
  output logic [ROB_IDX_WIDTH-1:0]  iss_rob_idx,
  output logic [PREG_IDX_WIDTH-1:0] iss_rd_tag,
  output logic                      iss_rd_is_fp,
  output logic [PTR_W-1:0]          count
);

  logic [PTR_W-1:0]          head, tail;
  logic [IDX_W-1:0]          head_idx, tail_idx;
  logic [DEPTH-1:0]          valid;
  logic [DEPTH-1:0]          base_rdy, data_rdy;
  logic [31:0]               base_val [DEPTH];
  logic [31:0]               data_val [DEPTH];
  logic [31:0]               imm_q    [DEPTH];
  logic [MEM_OP_WIDTH-1:0]   mop_q    [DEPTH];
  logic [ROB_IDX_WIDTH-1:0]  rob_q    [DEPTH];
  logic [PREG_IDX_WIDTH-1:0] rd_q     [DEPTH];
  logic [DEPTH-1:0]          ld_q, uns_q, rdfp_q;
  logic                      full, empty, disp_fire;

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign full      = (head[PTR_W-1] != tail[PTR_W-1]) && (head_idx == tail_idx);
  assign empty     = (head == tail);
  assign count     = tail - head;
  assign disp_ready = !full;
  assign disp_fire = disp_valid && !full && !flush;

  // Head issues only when both operands were ready before this cycle's edge.
  assign iss_valid = !empty && base_rdy[head_idx] && data_rdy[head_idx] && !lsu_busy && !flush;

  assign iss_addr     = base_val[head_idx] + imm_q[head_idx];
  assign iss_wdata    = data_val[head_idx];
  assign iss_mem_op   = mop_q[head_idx];
  assign iss_is_load  = ld_q[head_idx];
  assign iss_unsigned = uns_q[head_idx];
  assign iss_rob_idx  = rob_q[head_idx];
  assign iss_rd_tag   = rd_q[head_idx];
  assign iss_rd_is_fp = rdfp_q[head_idx];

  // Pointer and valid-bit bookkeeping; flush discards everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else begin
      // Dispatch and issue never target the same slot: that needs empty or full.
      if (disp_fire) begin
        tail            <= tail + 1'b1;
        valid[tail_idx] <= 1'b1;
      end
      if (iss_valid) begin
        head            <= head + 1'b1;
        valid[head_idx] <= 1'b0;
      end
    end
  end

  // Non-operand payload written at dispatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        mop_q[i] <= '0;
        rob_q[i] <= '0;
        rd_q[i]  <= '0;
      end
      ld_q   <= '0;
      uns_q  <= '0;
      rdfp_q <= '0;
    end else if (disp_fire) begin
      imm_q[tail_idx]  <= disp_imm;
      mop_q[tail_idx]  <= disp_mem_op;
      rob_q[tail_idx]  <= disp_rob_idx;
      rd_q[tail_idx]   <= disp_rd_tag;
      ld_q[tail_idx]   <= disp_is_load;
      uns_q[tail_idx]  <= disp_unsigned;
      rdfp_q[tail_idx] <= disp_rd_is_fp;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      logic wr;
      assign wr = disp_fire && (tail_idx == IDX_W'(g));

      // Base address operand always lives in the integer file.
      miq_operand_slot #(.PREG_W(PREG_IDX_WIDTH)) u_base (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .entry_valid(valid[g]),
        .wr         (wr),
        .wr_tag     (disp_base_tag),
        .wr_fp      (1'b0),
        .wr_rdy     (disp_base_rdy),
        .wr_val     (disp_base_val),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_is_fp  (cdb_is_fp),
        .cdb_value  (cdb_value),
        .rdy        (base_rdy[g]),
        .val        (base_val[g])
      );

      miq_operand_slot #(.PREG_W(PREG_IDX_WIDTH)) u_data (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .entry_valid(valid[g]),
        .wr         (wr),
        .wr_tag     (disp_data_tag),
        .wr_fp      (disp_data_fp),
        .wr_rdy     (disp_data_rdy),
        .wr_val     (disp_data_val),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_is_fp  (cdb_is_fp),
        .cdb_value  (cdb_value),
        .rdy        (data_rdy[g]),
        .val        (data_val[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared a few ns later.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = MIQ_PREG_IDX_W;
  localparam int RW    = MIQ_ROB_IDX_W;
  localparam int MW    = MIQ_MEM_OP_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush, d_valid, d_brdy, d_dfp, d_drdy, d_ld, d_uns, d_rdfp;
  logic [PW-1:0] d_btag, d_dtag, d_rd;
  logic [31:0]   d_bval, d_dval, d_imm;
  logic [MW-1:0] d_mop;
  logic [RW-1:0] d_rob;
  logic          c_valid, c_fp, lsu_busy;
  logic [PW-1:0] c_tag;
  logic [31:0]   c_val;

  logic          disp_ready, iss_valid, iss_is_load, iss_unsigned, iss_rd_is_fp;
  logic [31:0]   iss_addr, iss_wdata;
  logic [MW-1:0] iss_mem_op;
  logic [RW-1:0] iss_rob_idx;
  logic [PW-1:0] iss_rd_tag;
  logic [3:0]    count;

  typedef struct {
    logic [PW-1:0] btag; logic brdy; logic [31:0] bval;
    logic [PW-1:0] dtag; logic dfp;  logic drdy; logic [31:0] dval;
    logic [31:0] imm; logic [MW-1:0] mop; logic ld; logic uns;
    logic [RW-1:0] rob; logic [PW-1:0] rd; logic rdfp;
  } m_ent_t;

  m_ent_t       q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [RW-1:0] rob_ctr = '0;
  logic [RW-1:0] rob_a, rob_b;

  always #5 clk = ~clk;

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(d_valid), .disp_ready(disp_ready),
    .disp_base_tag(d_btag), .disp_base_rdy(d_brdy), .disp_base_val(d_bval),
    .disp_data_tag(d_dtag), .disp_data_fp(d_dfp), .disp_data_rdy(d_drdy), .disp_data_val(d_dval),
    .disp_imm(d_imm), .disp_mem_op(d_mop), .disp_is_load(d_ld), .disp_unsigned(d_uns),
    .disp_rob_idx(d_rob), .disp_rd_tag(d_rd), .disp_rd_is_fp(d_rdfp),
    .cdb_valid(c_valid), .cdb_tag(c_tag), .cdb_is_fp(c_fp), .cdb_value(c_val),
    .lsu_busy(lsu_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_wdata(iss_wdata), .iss_mem_op(iss_mem_op),
    .iss_is_load(iss_is_load), .iss_unsigned(iss_unsigned), .iss_rob_idx(iss_rob_idx),
    .iss_rd_tag(iss_rd_tag), .iss_rd_is_fp(iss_rd_is_fp), .count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_valid = 0; d_brdy = 0; d_bval = 0; d_btag = 0; d_dtag = 0; d_dfp = 0; d_drdy = 0;
    d_dval = 0; d_imm = 0; d_mop = 0; d_ld = 0; d_uns = 0; d_rob = 0; d_rd = 0; d_rdfp = 0;
    c_valid = 0; c_tag = 0; c_fp = 0; c_val = 0; flush = 0; lsu_busy = 0;
  endtask

  task automatic disp(input logic ld, input logic brdy, input logic [31:0] bval, input logic [PW-1:0] btag,
                      input logic drdy, input logic [31:0] dval, input logic [PW-1:0] dtag,
                      input logic dfp, input logic [31:0] imm);
    d_valid = 1; d_ld = ld; d_brdy = brdy; d_bval = bval; d_btag = btag;
    d_drdy = ld ? 1'b1 : drdy; d_dval = dval; d_dtag = dtag; d_dfp = dfp; d_imm = imm;
    d_mop = MW'($urandom_range(0, 3)); d_uns = 1'($urandom); d_rd = PW'($urandom);
    d_rdfp = 1'($urandom); d_rob = rob_ctr; rob_ctr = rob_ctr + 1'b1;
  endtask

  // Compare every output against the model, then advance the model across the clock edge.
  task automatic cycle();
    bit     exp_iss, fire_disp;
    m_ent_t e;
    #2;
    exp_iss   = (q.size() > 0) && q[0].brdy && q[0].drdy && !lsu_busy && !flush;
    fire_disp = d_valid && (q.size() < DEPTH) && !flush;
    check("count", 32'(count), 32'(q.size()));
    check("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
    check("iss_valid", 32'(iss_valid), 32'(exp_iss));
    if (exp_iss) begin
      check("iss_addr", iss_addr, q[0].bval + q[0].imm);
      check("iss_wdata", iss_wdata, q[0].dval);
      check("iss_rob_idx", 32'(iss_rob_idx), 32'(q[0].rob));
      check("iss_mem_op", 32'(iss_mem_op), 32'(q[0].mop));
      check("iss_flags", {28'd0, iss_is_load, iss_unsigned, iss_rd_is_fp, 1'b0},
            {28'd0, q[0].ld, q[0].uns, q[0].rdfp, 1'b0});
      check("iss_rd_tag", 32'(iss_rd_tag), 32'(q[0].rd));
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      foreach (q[i]) begin
        if (c_valid && !q[i].brdy && !c_fp && c_tag == q[i].btag) begin
          q[i].brdy = 1; q[i].bval = c_val;
        end
        if (c_valid && !q[i].drdy && c_fp == q[i].dfp && c_tag == q[i].dtag) begin
          q[i].drdy = 1; q[i].dval = c_val;
        end
      end
      if (exp_iss) void'(q.pop_front());
      if (fire_disp) begin
        e = '{btag: d_btag, brdy: d_brdy, bval: d_bval, dtag: d_dtag, dfp: d_dfp, drdy: d_drdy,
              dval: d_dval, imm: d_imm, mop: d_mop, ld: d_ld, uns: d_uns, rob: d_rob, rd: d_rd,
              rdfp: d_rdfp};
        if (!e.brdy && c_valid && !c_fp && c_tag == e.btag) begin
          e.brdy = 1; e.bval = c_val;
        end
        if (!e.drdy && c_valid && c_fp == e.dfp && c_tag == e.dtag) begin
          e.drdy = 1; e.dval = c_val;
        end
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic random_cycle();
    idle();
    if ($urandom_range(0, 9) < 6)
      disp(1'($urandom), 1'($urandom), $urandom, PW'($urandom_range(0, 7)), 1'($urandom), $urandom,
           PW'($urandom_range(0, 7)), 1'($urandom), $urandom);
    c_valid  = 1'($urandom);
    c_tag    = PW'($urandom_range(0, 7));
    c_fp     = 1'($urandom);
    c_val    = $urandom;
    lsu_busy = ($urandom_range(0, 3) == 0);
    flush    = ($urandom_range(0, 49) == 0);
    cycle();
  endtask

  initial begin
    idle();
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_disp_ready", 32'(disp_ready), 1);
    check("rst_iss_valid", 32'(iss_valid), 0);
    @(negedge clk);
    rst = 0;

    // Load with ready base issues the following cycle at base+imm.
    idle();
    disp(1, 1, 32'h1000, 0, 1, 0, 0, 0, 32'h10);
    #1 check("t1_iss_same_cycle", 32'(iss_valid), 0);
    cycle();
    idle();
    #1 check("t1_iss", 32'(iss_valid), 1);
    check("t1_addr", iss_addr, 32'h1010);
    cycle();
    #1 check("t1_count", 32'(count), 0);

    // Store waiting on integer tag 5: FP broadcast ignored, no same-cycle bypass to issue.
    idle();
    disp(0, 1, 32'h2000, 1, 0, 0, 5, 0, 32'h4);
    cycle();
    idle();
    c_valid = 1; c_tag = 5; c_fp = 1; c_val = 32'hBEEF;
    #1 check("t2_fp_nowake", 32'(iss_valid), 0);
    cycle();
    c_fp = 0; c_val = 32'hDEAD;
    #1 check("t2_still_blocked", 32'(iss_valid), 0);
    cycle();
    idle();
    #1 check("t2_iss", 32'(iss_valid), 1);
    check("t2_wdata", iss_wdata, 32'hDEAD);
    cycle();

    // Fill to full; an issue cycle still refuses dispatch.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); lsu_busy = 1;
      disp(1'($urandom), 1, $urandom, 0, 1, $urandom, 0, 0, $urandom);
      cycle();
    end
    idle(); lsu_busy = 1;
    #1 check("t3_count_full", 32'(count), DEPTH);
    check("t3_ready_full", 32'(disp_ready), 0);
    idle();
    disp(1, 1, 0, 0, 1, 0, 0, 0, 0);
    #1 check("t3_iss_full", 32'(iss_valid), 1);
    check("t3_refused", 32'(disp_ready), 0);
    cycle();
    idle();
    #1 check("t3_count_after", 32'(count), DEPTH - 1);
    check("t3_ready_after", 32'(disp_ready), 1);
    for (int i = 0; i < 20; i++) begin
      idle();
      disp(1'($urandom), 1, $urandom, 0, 1, $urandom, 0, 0, $urandom);
      cycle();
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle();
      cycle();
    end

    // Unready head blocks a ready younger entry.
    idle();
    rob_a = rob_ctr;
    disp(1, 0, 0, 3, 1, 0, 0, 0, 32'h8);
    cycle();
    idle();
    rob_b = rob_ctr;
    disp(1, 1, 32'h500, 0, 1, 0, 0, 0, 0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      idle();
      #1 check("t4_blocked", 32'(iss_valid), 0);
      cycle();
    end
    idle();
    c_valid = 1; c_tag = 3; c_fp = 0; c_val = 32'h3000;
    cycle();
    idle();
    #1 check("t4_head_iss", 32'(iss_valid), 1);
    check("t4_head_rob", 32'(iss_rob_idx), 32'(rob_a));
    check("t4_head_addr", iss_addr, 32'h3008);
    cycle();
    #1 check("t4_young_rob", 32'(iss_rob_idx), 32'(rob_b));
    cycle();

    // LSU busy holds a ready head; it issues exactly once when released.
    idle(); lsu_busy = 1;
    disp(1, 1, 32'h40, 0, 1, 0, 0, 0, 32'h4);
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); lsu_busy = 1;
      #1 check("t5_busy_hold", 32'(iss_valid), 0);
      cycle();
    end
    idle();
    #1 check("t5_release", 32'(iss_valid), 1);
    cycle();
    #1 check("t5_once", 32'(iss_valid), 0);
    cycle();

    // Flush beats dispatch and issue.
    idle(); lsu_busy = 1;
    disp(1, 1, 32'h80, 0, 1, 0, 0, 0, 0);
    cycle();
    idle(); flush = 1;
    disp(1, 1, 32'h90, 0, 1, 0, 0, 0, 0);
    #1 check("t6_flush_iss", 32'(iss_valid), 0);
    cycle();
    idle();
    #1 check("t6_flush_count", 32'(count), 0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) random_cycle();

    // Asynchronous reset while the clock is low.
    idle(); lsu_busy = 1;
    disp(1, 1, 0, 0, 1, 0, 0, 0, 0);
    cycle();
    idle();
    #3 rst = 1;
    #1 check("rst_mid_count", 32'(count), 0);
    check("rst_mid_ready", 32'(disp_ready), 1);
    check("rst_mid_iss", 32'(iss_valid), 0);
    q.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 60; i++) random_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
